ifu_bht_ctl: RTL and testbench

IFU_BHT_CTL -- requirements
Module: ifu_bht_ctl

---
 rtl/ifu_bht_ctl_pkg.sv | 23 ++
 rtl/ifu_ret_stack.sv | 59 +++++
 rtl/ifu_bht_ctl.sv | 108 ++++++++++
 tb/tb_ifu_bht_ctl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_bht_ctl_pkg.sv
// Shared definitions for the branch history table controller: hist-state
// encoding, the prediction packet and a saturating counter helper.
package ifu_bht_ctl_pkg;

  localparam logic [1:0] HIST_ST = 2'b11;  // strong taken
  localparam logic [1:0] HIST_WT = 2'b10;  // weak taken
  localparam logic [1:0] HIST_WN = 2'b00;  // weak not-taken
  localparam logic [1:0] HIST_SN = 2'b01;  // strong not-taken

  localparam int BHT_IDX_MAX_W = 8;

  typedef struct packed {
    logic                     valid;
    logic                     taken;
    logic [1:0]               hist;
    logic [BHT_IDX_MAX_W-1:0] index;
  } bht_pred_pkt_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ifu_ret_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored, and a simultaneous push+pop replaces the top.
module ifu_ret_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:1] push_addr,
  input  logic        pop,
  output logic        top_valid,
  output logic [31:1] top
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:1]   mem [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] ptr_inc, ptr_dec;
  logic          empty, full;
  logic          do_push, do_repl, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);

  // push+pop on an empty stack degenerates to a plain push
  assign do_push = push & (~pop | empty);
  assign do_repl = push & pop & ~empty;
  assign do_pop  = pop & ~push & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (do_push) begin
      ptr_q <= ptr_inc;
      if (!full) cnt_q <= cnt_q + CW'(1);
    end else if (do_pop) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // entry contents need no reset; the count masks stale data
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push)      mem[ptr_inc] <= push_addr;
      else if (do_repl) mem[ptr_q]   <= push_addr;
    end
  end

  assign top_valid = ~empty;
  assign top       = empty ? '0 : mem[ptr_q];

endmodule

// File: rtl/ifu_bht_ctl.sv
// Fetch-stage 2-bit branch history table with 1-cycle lookup, write-through
// update bypass and mispredict counter. BHT_RET_STACK_EN adds the return stack.
import ifu_bht_ctl_pkg::*;

module ifu_bht_ctl #(
  parameter int BHT_ENTRIES = 64,
  parameter int RS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           flush,
  input  logic                           lookup_valid,
  input  logic [31:1]                    lookup_pc,
  output logic                           pred_valid,
  output logic                           pred_taken,
  output logic [1:0]                     pred_hist,
  output logic [$clog2(BHT_ENTRIES)-1:0] pred_index,
  input  logic                           upd_valid,
  input  logic [$clog2(BHT_ENTRIES)-1:0] upd_index,
  input  logic [1:0]                     upd_hist,
  input  logic                           upd_misp,
  output logic [15:0]                    misp_count,
  input  logic                           rs_push,
  input  logic [31:1]                    rs_push_addr,
  input  logic                           rs_pop,
  output logic                           rs_top_valid,
  output logic [31:1]                    rs_top
);

  localparam int IW = $clog2(BHT_ENTRIES);

  logic [1:0]    bht_q [BHT_ENTRIES];
  logic [IW-1:0] lk_index;
  logic [1:0]    lk_hist;
  bht_pred_pkt_t pred_q, pred_d;
  logic [15:0]   misp_q;

  assign lk_index = lookup_pc[IW:1] ^ lookup_pc[2*IW:IW+1];
  assign lk_hist  = (upd_valid && (upd_index == lk_index)) ? upd_hist : bht_q[lk_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= HIST_WN;
    end else if (upd_valid) begin
      bht_q[upd_index] <= upd_hist;
    end
  end

  // flush beats freeze; freeze holds the whole packet
  always_comb begin
    pred_d = pred_q;
    if (flush) begin
      pred_d.valid = 1'b0;
    end else if (!freeze) begin
      pred_d.valid = lookup_valid;
      if (lookup_valid) begin
        pred_d.taken = lk_hist[1];
        pred_d.hist  = lk_hist;
        pred_d.index = BHT_IDX_MAX_W'(lk_index);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pred_q <= '0;
    else     pred_q <= pred_d;
  end

  always_ff @(posedge clk) begin
    if (rst)                        misp_q <= '0;
    else if (upd_valid && upd_misp) misp_q <= sat_inc16(misp_q);
  end

  assign pred_valid = pred_q.valid;
  assign pred_taken = pred_q.taken;
  assign pred_hist  = pred_q.hist;
  assign pred_index = pred_q.index[IW-1:0];
  assign misp_count = misp_q;

  logic unused_pc;
  assign unused_pc = ^lookup_pc[31:2*IW+1];

  if (IW < BHT_IDX_MAX_W) begin : g_idx_pad
    logic unused_idx;
    assign unused_idx = ^pred_q.index[BHT_IDX_MAX_W-1:IW];
  end

`ifdef BHT_RET_STACK_EN
  ifu_ret_stack #(
    .DEPTH(RS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (rs_push),
    .push_addr (rs_push_addr),
    .pop       (rs_pop),
    .top_valid (rs_top_valid),
    .top       (rs_top)
  );
`else
  logic unused_rs;
  assign unused_rs    = ^{rs_push, rs_pop, rs_push_addr};
  assign rs_top_valid = 1'b0;
  assign rs_top       = '0;
`endif

endmodule

// File: tb/tb_ifu_bht_ctl.sv
// Directed bench for ifu_bht_ctl: prediction scoreboard backed by a table
// model, mispredict saturation, and return-stack model when enabled.
import ifu_bht_ctl_pkg::*;

module tb_ifu_bht_ctl;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, lookup_valid;
  logic [31:1] lookup_pc;
  logic        pred_valid, pred_taken;
  logic [1:0]  pred_hist;
  logic [5:0]  pred_index;
  logic        upd_valid, upd_misp;
  logic [5:0]  upd_index;
  logic [1:0]  upd_hist;
  logic [15:0] misp_count;
  logic        rs_push, rs_pop, rs_top_valid;
  logic [31:1] rs_push_addr, rs_top;

  int total = 0;
  int bad   = 0;

  bht_pred_pkt_t sb_q[$];
  bht_pred_pkt_t last_exp;
  logic [1:0]    model_bht [64];
  logic [30:0]   rs_model[$];

  ifu_bht_ctl #(.BHT_ENTRIES(64), .RS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .pred_index(pred_index), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_hist(upd_hist), .upd_misp(upd_misp), .misp_count(misp_count),
    .rs_push(rs_push), .rs_push_addr(rs_push_addr), .rs_pop(rs_pop),
    .rs_top_valid(rs_top_valid), .rs_top(rs_top)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] m_idx(input logic [31:0] pc);
    return 6'(((pc >> 1) ^ (pc >> 7)) & 32'h3F);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    freeze = 0; flush = 0; lookup_valid = 0; lookup_pc = '0;
    upd_valid = 0; upd_index = '0; upd_hist = 2'b00; upd_misp = 0;
    rs_push = 0; rs_pop = 0; rs_push_addr = '0;
  endtask

  // one clock; table model follows the DUT's write at the edge
  task automatic cyc();
    logic        u_v  = upd_valid;
    logic [5:0]  u_i  = upd_index;
    logic [1:0]  u_h  = upd_hist;
    @(posedge clk);
    #1;
    if (rst) for (int i = 0; i < 64; i++) model_bht[i] = 2'b00;
    else if (u_v) model_bht[u_i] = u_h;
  endtask

  task automatic drive_lookup(input logic [31:0] pc);
    bht_pred_pkt_t e;
    logic [5:0] idx;
    logic [1:0] h;
    idx = m_idx(pc);
    h   = (upd_valid && upd_index == idx) ? upd_hist : model_bht[idx];
    e.valid = 1'b1; e.taken = h[1]; e.hist = h; e.index = 8'(idx);
    sb_q.push_back(e);
    lookup_valid = 1'b1;
    lookup_pc    = pc[31:1];
  endtask

  task automatic check_pred(input string tag);
    bht_pred_pkt_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    last_exp = e;
    chk(tag, {20'd0, pred_valid, pred_taken, pred_hist, 2'b00, pred_index}, {20'd0, e});
  endtask

  task automatic rs_step(input logic push, input logic pop, input logic [30:0] addr);
    rs_push = push; rs_pop = pop; rs_push_addr = addr;
    cyc();
    rs_push = 0; rs_pop = 0;
    if (push && pop && rs_model.size() > 0) rs_model[rs_model.size()-1] = addr;
    else if (push) begin
      rs_model.push_back(addr);
      if (rs_model.size() > 4) void'(rs_model.pop_front());
    end else if (pop && rs_model.size() > 0) void'(rs_model.pop_back());
  endtask

  task automatic rs_check(input string tag);
    logic [30:0] t;
    t = (rs_model.size() > 0) ? rs_model[rs_model.size()-1] : 31'd0;
    chk({tag, "_valid"}, {31'd0, rs_top_valid}, {31'd0, rs_model.size() > 0});
    chk({tag, "_top"}, {1'b0, rs_top}, {1'b0, t});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model_bht[i] = 2'b00;
    clr();
    rst = 1; cyc(); cyc();
    rst = 0;

    drive_lookup(32'h40); cyc(); check_pred("lk_before_rst");
    rst = 1; lookup_valid = 1; cyc();
    chk("rst_pred_pkt", {29'd0, pred_valid, pred_hist}, 32'd0);
    chk("rst_pred_taken_idx", {25'd0, pred_taken, pred_index}, 32'd0);
    chk("rst_misp", {16'd0, misp_count}, 32'd0);
    chk("rst_rs", {rs_top_valid, rs_top}, 32'd0);
    rst = 0; clr();

    drive_lookup(32'h100); cyc(); check_pred("lk100_cold");
    chk("lk100_cold_hist", {30'd0, pred_hist}, 32'd0);

    clr(); upd_valid = 1; upd_index = m_idx(32'h100); upd_hist = 2'b11; cyc();
    chk("idle_no_pred", {31'd0, pred_valid}, 32'd0);
    clr(); drive_lookup(32'h100); cyc(); check_pred("lk100_trained");
    chk("lk100_taken", {31'd0, pred_taken}, 32'd1);

    clr(); upd_valid = 1; upd_index = m_idx(32'h300); upd_hist = 2'b11;
    drive_lookup(32'h300); cyc(); check_pred("bypass_11");
    clr(); upd_valid = 1; upd_index = m_idx(32'h2468); upd_hist = 2'b10;
    drive_lookup(32'h2468); cyc(); check_pred("bypass_10");
    clr(); upd_valid = 1; upd_index = m_idx(32'h300) ^ 6'd1; upd_hist = 2'b01;
    drive_lookup(32'h300); cyc(); check_pred("no_bypass_other_idx");

    clr(); drive_lookup(32'h100); cyc(); check_pred("pre_freeze");
    clr(); freeze = 1; lookup_valid = 1; lookup_pc = 31'h180;
    upd_valid = 1; upd_index = m_idx(32'h100); upd_hist = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cyc();
      upd_valid = 0;
      chk("freeze_hold", {20'd0, pred_valid, pred_taken, pred_hist, 2'b00, pred_index},
          {20'd0, last_exp});
    end
    flush = 1; cyc();
    chk("flush_in_freeze", {31'd0, pred_valid}, 32'd0);
    clr(); drive_lookup(32'h100); cyc(); check_pred("upd_during_freeze");
    clr(); lookup_valid = 1; lookup_pc = 31'h90; flush = 1; cyc();
    chk("flush_kill", {31'd0, pred_valid}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] pc;
      clr();
      pc = $urandom;
      upd_valid = 1'($urandom_range(0, 1));
      upd_index = (i % 3 == 0) ? m_idx(pc) : 6'($urandom_range(0, 63));
      upd_hist  = 2'($urandom_range(0, 3));
      drive_lookup(pc); cyc(); check_pred("rand_lookup");
    end

    clr(); upd_valid = 1; upd_misp = 1;
    repeat (65534) cyc();
    chk("misp_fffe", {16'd0, misp_count}, 32'hFFFE);
    upd_misp = 0; cyc();
    chk("misp_no_inc_nomisp", {16'd0, misp_count}, 32'hFFFE);
    upd_valid = 0; upd_misp = 1; cyc();
    chk("misp_no_inc_noupd", {16'd0, misp_count}, 32'hFFFE);
    upd_valid = 1; cyc();
    chk("misp_ffff", {16'd0, misp_count}, 32'hFFFF);
    cyc(); cyc();
    chk("misp_sat", {16'd0, misp_count}, 32'hFFFF);
    clr();

`ifdef BHT_RET_STACK_EN
    rs_check("rs_empty");
    for (int i = 0; i < 5; i++) begin
      rs_step(1, 0, 31'h1000 + 31'(i)); rs_check("rs_push");
    end
    for (int i = 0; i < 4; i++) begin
      rs_step(0, 1, '0); rs_check("rs_pop");
    end
    chk("rs_empty_after4", {31'd0, rs_top_valid}, 32'd0);
    rs_step(0, 1, '0); rs_check("rs_pop_empty");
    rs_step(1, 0, 31'h0AAA); rs_check("rs_push_a");
    rs_step(1, 1, 31'h0777); rs_check("rs_replace");
    chk("rs_replace_x", {1'b0, rs_top}, 32'h777);
    rs_step(0, 1, '0); rs_check("rs_count_one");
    rs_step(1, 1, 31'h0555); rs_check("rs_pushpop_empty");
`else
    for (int i = 0; i < 3; i++) begin
      rs_push = 1; rs_pop = (i == 2); rs_push_addr = 31'h1234 + 31'(i);
      cyc();
      chk("rs_absent", {rs_top_valid, rs_top}, 32'd0);
    end
    clr();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
